// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// for the MEM stage. Hits resolve combinationally with zero stall cycles.
// A miss transfers a whole line to or from data memory over a
// request/ready handshake, then pulses d_ready so the pipeline can replay
// the access, which then hits.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | serving hits; a miss latches index/tag and leaves this state
// WRITEBACK  | dirty victim line is being written to memory
// FILL       | requested line is being read from memory
// DONE       | one-cycle d_ready pulse; the replayed access comes next cycle
module d_cache_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [WORD_SIZE-1:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            d_cache_hit,
  output logic                            d_ready,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_ready,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FILL      = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]             state_q, state_d;
  logic [NUM_LINES-1:0]   line_valid;
  logic [NUM_LINES-1:0]   line_dirty;
  logic [TAG_W-1:0]       line_tag  [NUM_LINES];
  logic [LINE_W-1:0]      line_data [NUM_LINES];
  logic [IDX_W-1:0]       miss_idx_q;
  logic [TAG_W-1:0]       miss_tag_q;
  logic                   replay_q;
  logic [15:0]            hit_count_q;
  logic [15:0]            miss_count_q;

  logic                   req;
  logic                   is_write;
  logic [OFF_W-1:0]       off;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   miss;
  logic                   wb_done;
  logic                   fill_done;

  assign req       = cpu_read | cpu_write;
  assign is_write  = cpu_write;
  assign off       = cpu_addr[OFF_W-1:0];
  assign idx       = cpu_addr[OFF_W +: IDX_W];
  assign tag       = cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign hit       = req && (state_q == S_IDLE) && line_valid[idx] && (line_tag[idx] == tag);
  assign miss      = req && (state_q == S_IDLE) && !hit;
  assign wb_done   = (state_q == S_WRITEBACK) && mem_ready;
  assign fill_done = (state_q == S_FILL) && mem_ready;

  // Next-state logic; mem_ready is only honoured in the transfer states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (miss) state_d = (line_valid[idx] && line_dirty[idx]) ? S_WRITEBACK : S_FILL;
      S_WRITEBACK: if (mem_ready) state_d = S_FILL;
      S_FILL:      if (mem_ready) state_d = S_DONE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, line status bits, latched miss address, counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      line_valid   <= '0;
      line_dirty   <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      replay_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q  <= state_d;
      replay_q <= (state_q == S_DONE);
      if (miss) begin
        miss_idx_q <= idx;
        miss_tag_q <= tag;
        if (miss_count_q != CNT_MAX) miss_count_q <= miss_count_q + 16'd1;
      end
      // The replayed access right after DONE belongs to the miss already counted.
      if (hit && !replay_q && (hit_count_q != CNT_MAX)) hit_count_q <= hit_count_q + 16'd1;
      if (hit && is_write) line_dirty[idx] <= 1'b1;
      if (wb_done) line_dirty[miss_idx_q] <= 1'b0;
      if (fill_done) begin
        line_valid[miss_idx_q] <= 1'b1;
        line_dirty[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      line_data[miss_idx_q] <= mem_rdata;
      line_tag[miss_idx_q]  <= miss_tag_q;
    end else if (hit && is_write) begin
      line_data[idx][off*WORD_SIZE +: WORD_SIZE] <= cpu_wdata;
    end
  end

  // CPU-side and memory-side outputs decoded from state and latched miss address.
  always_comb begin
    d_cache_hit = (state_q == S_IDLE) && (!req || hit);
    cpu_rdata   = (hit && !is_write) ? line_data[idx][off*WORD_SIZE +: WORD_SIZE] : '0;
    d_ready     = (state_q == S_DONE);
    mem_read    = (state_q == S_FILL);
    mem_write   = (state_q == S_WRITEBACK);
    mem_addr    = '0;
    mem_wdata   = '0;
    if (state_q == S_WRITEBACK) begin
      mem_addr  = {line_tag[miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
      mem_wdata = line_data[miss_idx_q];
    end else if (state_q == S_FILL) begin
      mem_addr  = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
